// File: rtl/c2c_data_arb.sv
// rtl/c2c_data_arb.sv - round-robin N-channel arbiter for the core-to-cache data bus
//
// Merges NCH master request channels onto one cache-side slave channel with one
// outstanding transaction at a time. Arbitration happens in IDLE, the winner is
// registered onto s_* and held through BUSY until the cache acks.
//
// Parameters: XLEN (data/address width), NCH (2..16 channels), TIMEOUT (ack
// timeout in cycles, only used when C2C_ARB_TIMEOUT_EN is defined).
//
// Optional feature macro: C2C_ARB_TIMEOUT_EN - adds a BUSY-cycle counter that
// completes the transaction with m_err=1 if the cache does not ack in time.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   m_re, m_we              per-channel read/write request (NCH)
//   m_sel, m_addr, m_data_w per-channel byte selects/address/write data, packed
//   m_ack                   one-hot completion pulse to the granted channel
//   m_data_r, m_err         shared read data and error flag, valid with m_ack
//   s_re, s_we, s_sel,
//   s_addr, s_data_w        registered request to the cache
//   s_ack, s_data_r         cache completion pulse and read data
module c2c_data_arb #(
    parameter int XLEN    = 32,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         m_re,
    input  logic [NCH-1:0]         m_we,
    input  logic [NCH*XLEN/8-1:0]  m_sel,
    input  logic [NCH*XLEN-1:0]    m_addr,
    input  logic [NCH*XLEN-1:0]    m_data_w,
    output logic [NCH-1:0]         m_ack,
    output logic [XLEN-1:0]        m_data_r,
    output logic                   m_err,
    output logic                   s_re,
    output logic                   s_we,
    output logic [XLEN/8-1:0]      s_sel,
    output logic [XLEN-1:0]        s_addr,
    output logic [XLEN-1:0]        s_data_w,
    input  logic                   s_ack,
    input  logic [XLEN-1:0]        s_data_r
);

    localparam int SW = XLEN / 8;
    localparam int PW = $clog2(NCH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]     grant_q, grant_d;
    logic              s_re_q, s_re_d;
    logic              s_we_q, s_we_d;
    logic [SW-1:0]     s_sel_q, s_sel_d;
    logic [XLEN-1:0]   s_addr_q, s_addr_d;
    logic [XLEN-1:0]   s_data_w_q, s_data_w_d;

    logic [NCH-1:0]    req;
    logic              any_req;
    logic [PW-1:0]     win;
    logic [PW-1:0]     scan_idx;
    logic [SW-1:0]     win_sel;
    logic [XLEN-1:0]   win_addr;
    logic [XLEN-1:0]   win_data_w;
    logic              ack_ok;
    logic              timeout_hit;

    assign req    = m_re | m_we;
    assign ack_ok = (state_q == BUSY) && s_ack;

    // Round-robin pick: scan from the highest offset down so the last hit,
    // which is the one nearest rr_ptr, wins.
    always_comb begin
        any_req  = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            scan_idx = PW'((int'(rr_ptr_q) + k) % NCH);
            if (req[scan_idx]) begin
                any_req = 1'b1;
                win     = scan_idx;
            end
        end
    end

    always_comb begin
        win_sel    = '0;
        win_addr   = '0;
        win_data_w = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win == PW'(i)) begin
                win_sel    = m_sel[i*SW +: SW];
                win_addr   = m_addr[i*XLEN +: XLEN];
                win_data_w = m_data_w[i*XLEN +: XLEN];
            end
        end
    end

`ifdef C2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Held at zero outside BUSY so it is clear on every entry to BUSY;
    // saturates at TIMEOUT since the transaction ends that cycle anyway.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != BUSY) begin
            tmo_cnt_d = '0;
        end else if (!s_ack && (tmo_cnt_q != CW'(TIMEOUT))) begin
            tmo_cnt_d = tmo_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // s_ack has priority over a coincident timeout.
    assign timeout_hit = (state_q == BUSY) && !s_ack && (tmo_cnt_q == CW'(TIMEOUT));
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        s_re_d     = s_re_q;
        s_we_d     = s_we_q;
        s_sel_d    = s_sel_q;
        s_addr_d   = s_addr_q;
        s_data_w_d = s_data_w_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d    = BUSY;
                    grant_d    = win;
                    s_re_d     = m_re[win];
                    s_we_d     = m_we[win];
                    s_sel_d    = win_sel;
                    s_addr_d   = win_addr;
                    s_data_w_d = win_data_w;
                end
            end
            BUSY: begin
                if (ack_ok || timeout_hit) begin
                    state_d  = IDLE;
                    s_re_d   = 1'b0;
                    s_we_d   = 1'b0;
                    rr_ptr_d = (grant_q == PW'(NCH - 1)) ? '0 : grant_q + PW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            s_re_q     <= 1'b0;
            s_we_q     <= 1'b0;
            s_sel_q    <= '0;
            s_addr_q   <= '0;
            s_data_w_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            s_re_q     <= s_re_d;
            s_we_q     <= s_we_d;
            s_sel_q    <= s_sel_d;
            s_addr_q   <= s_addr_d;
            s_data_w_q <= s_data_w_d;
        end
    end

    // Completion is combinational from s_ack so the master sees it the same cycle.
    always_comb begin
        m_ack    = '0;
        m_data_r = '0;
        m_err    = 1'b0;
        if (ack_ok) begin
            m_ack[grant_q] = 1'b1;
            m_data_r       = s_data_r;
        end else if (timeout_hit) begin
            m_ack[grant_q] = 1'b1;
            m_err          = 1'b1;
        end
    end

    assign s_re     = s_re_q;
    assign s_we     = s_we_q;
    assign s_sel    = s_sel_q;
    assign s_addr   = s_addr_q;
    assign s_data_w = s_data_w_q;

endmodule
